// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: per-port requests and commands,
// plus the grant/done/err/rdata responses.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, done, err, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, done, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and single-access sequencer for the data memory.
// Optional per-port grant and conflict counters are built when DMEM_ARB_PERF_CNT_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       cnt_gnt0,
  output logic [31:0]       cnt_gnt1,
  output logic [31:0]       cnt_conflict
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [1:0]        gnt_r;
  logic [1:0]        done_r;
  logic              err_r;
  logic [DATA_W-1:0] rdata_r;
  logic              last_gnt;
  logic              sel;
  logic              we_lat;
  logic              err_flag;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic              winner;
  logic              oor;

  assign bus.gnt   = gnt_r;
  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;

  // On a tie the port that was not granted last wins, giving strict alternation.
  always_comb begin
    winner = (bus.req == 2'b11) ? ~last_gnt : bus.req[1];
  end

  assign oor = (addr_lat >= ADDR_W'(MEM_DEPTH));

  // Strobes are registered, so each state prepares the outputs seen in the next cycle:
  // ACCESS raises the strobe, RESP captures read data and raises done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gnt_r          <= '0;
      done_r         <= '0;
      err_r          <= 1'b0;
      rdata_r        <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      last_gnt       <= 1'b1;
      sel            <= 1'b0;
      we_lat         <= 1'b0;
      err_flag       <= 1'b0;
      addr_lat       <= '0;
      wdata_lat      <= '0;
    end else begin
      gnt_r  <= '0;
      done_r <= '0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_r     <= winner ? 2'b10 : 2'b01;
            sel       <= winner;
            last_gnt  <= winner;
            we_lat    <= winner ? bus.we[1]   : bus.we[0];
            addr_lat  <= winner ? bus.addr1   : bus.addr0;
            wdata_lat <= winner ? bus.wdata1  : bus.wdata0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_address    <= addr_lat;
          mem_write_data <= wdata_lat;
          mem_write      <= we_lat & ~oor;
          mem_read       <= ~we_lat & ~oor;
          err_flag       <= oor;
          state          <= RESP;
        end
        RESP: begin
          if (mem_read) rdata_r <= mem_read_data;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          done_r    <= sel ? 2'b10 : 2'b01;
          err_r     <= err_flag;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else if (state == IDLE && bus.req != 2'b00) begin
      if (winner) cnt_gnt1 <= cnt_gnt1 + 32'd1;
      else        cnt_gnt0 <= cnt_gnt0 + 32'd1;
      if (bus.req == 2'b11) cnt_conflict <= cnt_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural memory, a response scoreboard
// and one task per scenario.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b0;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_read;
  logic        mem_write;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] cnt_gnt0;
  logic [31:0] cnt_gnt1;
  logic [31:0] cnt_conflict;
`endif

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data)
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    .cnt_gnt0       (cnt_gnt0),
    .cnt_gnt1       (cnt_gnt1),
    .cnt_conflict   (cnt_conflict)
`endif
  );

  // Behavioural single-port memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:255];
  assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[1]   <= 32'h0101_0101;
      mem[2]   <= 32'h0202_0202;
      mem[5]   <= 32'hDEAD_BEEF;
      mem[40]  <= 32'h1111_1111;
      mem[255] <= 32'hFFFF_0000;
    end else if (mem_write && mem_address < 32'd256) begin
      mem[mem_address[7:0]] <= mem_write_data;
    end
  end

  typedef struct packed {
    logic [1:0]  done;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_x;
  logic [31:0] exp_rdata = 32'h0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (rst_n && bus.done != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got done=%b", bus.done);
      end else begin
        mon_x = sb.pop_front();
        if (bus.done !== mon_x.done || bus.err !== mon_x.err || bus.rdata !== mon_x.rdata) begin
          errors++;
          $display("FAIL response got done=%b err=%b rdata=%h required done=%b err=%b rdata=%h",
                   bus.done, bus.err, bus.rdata, mon_x.done, mon_x.err, mon_x.rdata);
        end
      end
    end
  end

  task automatic push(input logic [1:0] d, input logic e, input logic is_rd, input logic [31:0] v);
    exp_t x;
    if (is_rd && !e) exp_rdata = v;
    x.done  = d;
    x.err   = e;
    x.rdata = exp_rdata;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    bus.req = r; bus.we = w; bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
  endtask

  // One isolated transaction; after the grant, req drops and port 0 inputs become ca0/cd0.
  task automatic txn(input logic [1:0] r, input logic [1:0] w, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] ca0, input logic [31:0] cd0,
                     output logic [1:0] g, output logic rd, output logic wr,
                     output logic [31:0] ad, output logic [31:0] wd,
                     output logic prd, output logic pwr);
    @(negedge clk); drive(r, w, a0, a1, d0, d1);
    @(negedge clk); g = bus.gnt; bus.req = 2'b00; bus.addr0 = ca0; bus.wdata0 = cd0;
    @(negedge clk); rd = mem_read; wr = mem_write; ad = mem_address; wd = mem_write_data;
    @(negedge clk); prd = mem_read; pwr = mem_write;
    @(negedge clk);
  endtask

  logic [1:0]  g;
  logic        rd, wr, prd, pwr;
  logic [31:0] ad, wd;

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.gnt, bus.done, bus.err, mem_read, mem_write} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 0", {bus.gnt, bus.done, bus.err, mem_read, mem_write});
    end
    checks++;
    if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h required 0", bus.rdata); end
    checks++;
    if ({mem_address, mem_write_data} !== 64'h0) begin
      errors++; $display("FAIL reset_mem_bus got %h/%h required 0", mem_address, mem_write_data);
    end
`ifdef DMEM_ARB_PERF_CNT_EN
    checks++;
    if ({cnt_gnt0, cnt_gnt1, cnt_conflict} !== 96'h0) begin
      errors++; $display("FAIL reset_counters got %h/%h/%h required 0", cnt_gnt0, cnt_gnt1, cnt_conflict);
    end
`endif
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt, mem_read, mem_write} !== 4'b0) begin
      errors++; $display("FAIL idle_quiet got %b required 0", {bus.gnt, mem_read, mem_write});
    end
  endtask

  task automatic test_single_read();
    push(2'b01, 1'b0, 1'b1, 32'hDEAD_BEEF);
    txn(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if (g !== 2'b01) begin errors++; $display("FAIL read_gnt got %b required 01", g); end
    checks++;
    if ({rd, wr, ad} !== {1'b1, 1'b0, 32'd5}) begin
      errors++; $display("FAIL read_strobe got rd=%b wr=%b addr=%h required rd=1 wr=0 addr=5", rd, wr, ad);
    end
    checks++;
    if ({prd, pwr} !== 2'b00) begin errors++; $display("FAIL read_strobe_end got %b required 00", {prd, pwr}); end
  endtask

  task automatic test_write_readback();
    push(2'b10, 1'b0, 1'b0, 32'h0);
    txn(2'b10, 2'b10, 32'd0, 32'd10, 32'd0, 32'h1234_5678, 32'd0, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if (g !== 2'b10) begin errors++; $display("FAIL write_gnt got %b required 10", g); end
    checks++;
    if ({rd, wr, ad, wd} !== {1'b0, 1'b1, 32'd10, 32'h1234_5678}) begin
      errors++; $display("FAIL write_strobe got rd=%b wr=%b addr=%h data=%h required 0/1/a/12345678", rd, wr, ad, wd);
    end
    checks++;
    if ({prd, pwr} !== 2'b00) begin errors++; $display("FAIL write_one_cycle got %b required 00", {prd, pwr}); end
    push(2'b01, 1'b0, 1'b1, 32'h1234_5678);
    txn(2'b01, 2'b00, 32'd10, 32'd0, 32'd0, 32'd0, 32'd10, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if ({g, rd, ad} !== {2'b01, 1'b1, 32'd10}) begin
      errors++; $display("FAIL readback_access got gnt=%b rd=%b addr=%h required 01/1/a", g, rd, ad);
    end
  endtask

  task automatic test_out_of_range();
    push(2'b01, 1'b0, 1'b1, 32'hFFFF_0000);
    txn(2'b01, 2'b00, 32'd255, 32'd0, 32'd0, 32'd0, 32'd255, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if ({rd, wr} !== 2'b10) begin errors++; $display("FAIL addr255_strobe got %b required 10", {rd, wr}); end
    push(2'b01, 1'b1, 1'b1, 32'h0);
    txn(2'b01, 2'b00, 32'd256, 32'd0, 32'd0, 32'd0, 32'd256, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if ({g, rd, wr} !== 4'b0100) begin
      errors++; $display("FAIL addr256_strobe got gnt=%b rd=%b wr=%b required 01/0/0", g, rd, wr);
    end
    push(2'b10, 1'b1, 1'b0, 32'h0);
    txn(2'b10, 2'b10, 32'd0, 32'h8000_0000, 32'd0, 32'h5555_5555, 32'd0, 32'd0, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if ({g, rd, wr} !== 4'b1000) begin
      errors++; $display("FAIL addr_msb_strobe got gnt=%b rd=%b wr=%b required 10/0/0", g, rd, wr);
    end
  endtask

  task automatic test_input_change();
    push(2'b01, 1'b0, 1'b0, 32'h0);
    txn(2'b01, 2'b01, 32'd20, 32'd0, 32'hA5A5_A5A5, 32'd0, 32'd30, 32'hFFFF_FFFF, g, rd, wr, ad, wd, prd, pwr);
    checks++;
    if ({wr, ad, wd} !== {1'b1, 32'd20, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL latched_cmd got wr=%b addr=%h data=%h required 1/14/a5a5a5a5", wr, ad, wd);
    end
    checks++;
    if (mem[20] !== 32'hA5A5_A5A5 || mem[30] !== 32'h0) begin
      errors++; $display("FAIL latched_mem got m20=%h m30=%h required a5a5a5a5/0", mem[20], mem[30]);
    end
  endtask

  task automatic test_conflict();
    int n;
    int last;
    rst_n = 1'b0;
    drive(2'b11, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
    exp_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      push(2'b01, 1'b0, 1'b1, 32'h0101_0101);
      push(2'b10, 1'b0, 1'b1, 32'h0202_0202);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    last = 0;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) begin
        checks++;
        if (bus.gnt !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL conflict_gnt%0d got %b required %b", n, bus.gnt, (n % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 3) begin errors++; $display("FAIL conflict_spacing got %0d required 3", c - last); end
        end
        last = c;
        n++;
        if (n == 4) bus.req = 2'b00;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL conflict_grants got %0d required 4", n); end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
`ifdef DMEM_ARB_PERF_CNT_EN
    checks++;
    if ({cnt_gnt0, cnt_gnt1, cnt_conflict} !== {32'd2, 32'd2, 32'd4}) begin
      errors++; $display("FAIL conflict_counters got %0d/%0d/%0d required 2/2/4", cnt_gnt0, cnt_gnt1, cnt_conflict);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk); drive(2'b01, 2'b01, 32'd40, 32'd0, 32'hCAFE_F00D, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrst_gnt got %b required 01", bus.gnt); end
    bus.req = 2'b00;
    @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL midrst_strobe got %b required 1", mem_write); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_read, bus.done} !== 4'b0) begin
      errors++; $display("FAIL midrst_drop got %b required 0", {mem_write, mem_read, bus.done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem[40] !== 32'h1111_1111) begin
      errors++; $display("FAIL midrst_no_write got %h required 11111111", mem[40]);
    end
    push(2'b01, 1'b0, 1'b1, 32'h0101_0101);
    push(2'b10, 1'b0, 1'b1, 32'h0202_0202);
    drive(2'b11, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
    @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b01) begin errors++; $display("FAIL midrst_tie got %b required 01", bus.gnt); end
    bus.req = 2'b10;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.gnt !== 2'b10) begin errors++; $display("FAIL midrst_second got %b required 10", bus.gnt); end
    bus.req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    drive(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    test_reset();
    test_single_read();
    test_write_readback();
    test_out_of_range();
    test_input_change();
    test_conflict();
    test_reset_mid_write();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL pending_responses got %0d required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port data memory, which has a combinational read and mem_read/mem_write strobes.
- Port 0 is the core MEM stage. Port 1 is the loader/debug master.
- The block grants one requester at a time with round-robin priority and latches its command.
- It drives one memory access, then returns registered read data with a done pulse.

Parameters:
- ADDR_W, 32, requester and memory address width.
- DATA_W, 32, data width.
- MEM_DEPTH, 256, number of valid words; addresses >= MEM_DEPTH are errors.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  2  request per port; bit i = port i.
- we  input  2  per port: 1 = write, 0 = read; sampled with req.
- addr0, addr1  input  ADDR_W  per-port word address.
- wdata0, wdata1  input  DATA_W  per-port write data.
- gnt  output  2  one-hot, one-cycle pulse; the command is latched this cycle.
- done  output  2  one-hot, one-cycle pulse; the transaction has completed.
- err  output  1  one-cycle pulse with done; address out of range.
- rdata  output  DATA_W  read result; valid while done is high, held until the next read completes.
- mem_address  output  ADDR_W  to data memory.
- mem_write_data  output  DATA_W  to data memory.
- mem_read  output  1  to data memory.
- mem_write  output  1  to data memory.
- mem_read_data  input  DATA_W  from data memory; combinational.

Behaviour:
- States: IDLE, ACCESS, RESP. Encoding is free; the reset state is IDLE.
- Reset values: gnt=0, done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, last_gnt=1 (so port 0 wins the first tie).
- IDLE, req==0: stay in IDLE; memory strobes stay 0.
- IDLE, req!=0: choose a winner.
  - A single requester wins.
  - If both request, the winner is the port != last_gnt.
- On the winner, in the same cycle:
  - assert gnt[winner];
  - latch addr, wdata, we and winner id;
  - update last_gnt;
  - go to ACCESS.
- The requester may deassert req or change its inputs from the cycle after gnt; the latched copy is used.
- ACCESS, lasting exactly one cycle:
  - mem_address = latched addr and mem_write_data = latched wdata.
  - If the write flag is set, mem_write=1. Otherwise mem_read=1.
  - Both strobes are never high together.
  - If latched addr >= MEM_DEPTH, both strobes stay 0 and an error flag is set.
  - At the end of a read with no error, capture mem_read_data into rdata.
  - Go to RESP.
- RESP:
  - done[winner]=1; err=error flag.
  - rdata keeps its prior value on writes and error reads.
  - Strobes are 0. Return to IDLE.
- Latency: gnt is at cycle T; the memory strobe at T+1; done at T+2. Minimum spacing between grants is 3 cycles.
- A request held high through done is re-arbitrated in IDLE at T+3. It is treated as a new request.
- Starvation bound: when both ports request continuously, grants alternate 0,1,0,1...
- Strobes are registered outputs and never glitch. mem_address and mem_write_data hold their last values outside ACCESS.
- Asynchronous reset in any state:
  - return immediately to IDLE with all outputs at reset values;
  - the in-flight transaction is dropped, with no done and no further strobe;
  - a write whose ACCESS cycle was interrupted is not re-issued.
- Address compare is unsigned over the full ADDR_W.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- When defined, the block adds:
  - output cnt_gnt0 (32 bits) and output cnt_gnt1 (32 bits), which increment on each gnt of their port;
  - output cnt_conflict (32 bits), which increments on each IDLE cycle with req==2'b11 that produces a grant.
- All counters reset to 0, wrap modulo 2^32, and are unaffected by err.
- When not defined: no counter ports or logic, and the behaviour is otherwise identical.

Test Plan:
- Single read: reset; memory word 5 = 0xDEADBEEF; req=01, we=00, addr0=5.
  - gnt=01 at T, mem_read=1 with mem_address=5 at T+1.
  - done=01 and rdata=0xDEADBEEF at T+2; err=0.
- Single write then read back: port 1 writes 0x12345678 to 10.
  - mem_write=1 for exactly one cycle at T+1.
  - A later port 0 read of 10 returns 0x12345678.
- Conflict: req=11 held continuously from reset for 4 transactions.
  - gnt sequence is 01,10,01,10; grants are 3 cycles apart.
  - cnt_conflict=4 when the macro is defined.
- Out-of-range: port 0 read with addr0=256.
  - No mem_read or mem_write at T+1.
  - done=01 and err=1 at T+2; rdata unchanged.
- Reset mid-write: assert rst_n=0 during ACCESS of a write.
  - mem_write drops immediately; no done.
  - The state returns to IDLE, and the next request is granted normally with port 0 first on a tie.
- Input change after grant: change addr0 and wdata0 in the cycle after gnt.
  - The memory sees the originally latched values.
